// File: rtl/fetch_if.sv
// Fetch-to-decode handshake plus branch-unit redirect, grouped for the fetch_unit port list.
// master = fetch side (drives payload), slave = decode/branch side.
interface fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [31:0] pc_4_out;
    logic [31:0] pc_reg;
    logic        fetch_fire;

    modport master (
        input  redirect_valid, redirect_pc, ready_in,
        output valid_out, pc_out, instr_out, pc_4_out, pc_reg, fetch_fire
    );

    modport slave (
        output redirect_valid, redirect_pc, ready_in,
        input  valid_out, pc_out, instr_out, pc_4_out, pc_reg, fetch_fire
    );
endinterface

// File: rtl/fetch_unit.sv
// Front-end fetch: PC register, 1-cycle synchronous ROM, 2-entry output FIFO toward decode.
// Redirects flush the FIFO and drop any outstanding ROM read.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter              INIT_FILE  = "program.mem"
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.master fif
);
    localparam int IDX_W = $clog2(IMEM_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_4;
    } fetch_entry_t;

    logic [31:0]  rom [IMEM_DEPTH];
    logic [31:0]  rom_q;
    logic [31:0]  pc_q;
    logic         inflight;
    logic [31:0]  inflight_pc;
    fetch_entry_t fifo_q [2];
    logic         rd_ptr, wr_ptr;
    logic [1:0]   count;

    logic         valid, fire, push, issue;
    logic [2:0]   occ;

    assign valid = (count != 2'd0);
    assign fire  = valid && fif.ready_in;
    // Slots that will still be occupied after this edge; a new read may only
    // be issued if its response is guaranteed a free FIFO slot.
    assign occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, fire};
    assign issue = !fif.redirect_valid && (occ < 3'd2);
    assign push  = inflight && !fif.redirect_valid;

    always_ff @(posedge clk) begin
        if (issue) rom_q <= rom[pc_q[IDX_W+1:2]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= '0;
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
        end else if (fif.redirect_valid) begin
            pc_q     <= fif.redirect_pc & ~32'h3;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc_q;
                pc_q        <= pc_q + 32'd4;
            end
            if (push) begin
                fifo_q[wr_ptr] <= '{pc: inflight_pc, instr: rom_q, pc_4: inflight_pc + 32'd4};
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (fire) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {1'b0, push} - {1'b0, fire};
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(push && count == 2'd2));

    assign fif.valid_out  = valid;
    assign fif.pc_out     = fifo_q[rd_ptr].pc;
    assign fif.instr_out  = fifo_q[rd_ptr].instr;
    assign fif.pc_4_out   = fifo_q[rd_ptr].pc_4;
    assign fif.pc_reg     = pc_q;
    assign fif.fetch_fire = fire;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM[i]=i, table-driven cycle vectors plus scoreboard of presented PCs,
// followed by hand-written redirect / wrap / async-reset sequences.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_if fif();

    fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(1024), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .fif(fif)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] epc_reg;
    } vec_t;
    vec_t tbl [18];

    function automatic logic [31:0] rom_val(input logic [31:0] pc);
        return {22'b0, pc[11:2]};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_refill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(start + 32'(i * 4));
    endtask

    // Drive one cycle's inputs; any fire at the coming edge is scored against the queue.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] e;
        fif.redirect_valid = rv;
        fif.redirect_pc    = rpc;
        fif.ready_in       = rdy;
        #1;
        if (fif.valid_out && rdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: presented pc %h, expected none", fif.pc_out);
            end else begin
                e = exp_q.pop_front();
                cmp("sb_pc", fif.pc_out, e);
                cmp("sb_instr", fif.instr_out, rom_val(e));
                cmp("sb_pc4", fif.pc_4_out, e + 32'd4);
            end
        end
        if (rv) sb_refill(rpc & ~32'h3);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max);
        int k = 0;
        while (!fif.valid_out && k < max) begin
            step(1'b0, 32'h0, 1'b0);
            k++;
        end
        if (!fif.valid_out) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid: valid_out 0 after %0d cycles, expected 1", max);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = '0;
        fif.ready_in       = 1'b0;
        for (int i = 0; i < 1024; i++) dut.rom[i] = 32'(i);

        tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h4};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  32'h8};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'hC};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  32'h14};
        tbl[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 32'h18};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 32'h1C};
        tbl[13] = '{1'b0, 1'b1, 32'h40, 1'b1, 32'h14, 32'h1C};
        tbl[14] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h40};
        tbl[15] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h44};
        tbl[16] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'h48};
        tbl[17] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 32'h4C};

        repeat (2) @(negedge clk);
        cmp("rst_valid", {31'b0, fif.valid_out}, 32'h0);
        cmp("rst_pc_out", fif.pc_out, 32'h0);
        cmp("rst_instr", fif.instr_out, 32'h0);
        cmp("rst_pc4", fif.pc_4_out, 32'h0);
        cmp("rst_pc_reg", fif.pc_reg, 32'h0);
        cmp("rst_fire", {31'b0, fif.fetch_fire}, 32'h0);
        reset = 1'b0;
        sb_refill(32'h0);

        // Startup, 5-cycle backpressure, release, then redirect to 0x40 with a full FIFO.
        for (int v = 0; v < 18; v++) begin
            cmp($sformatf("v%0d_valid", v), {31'b0, fif.valid_out}, {31'b0, tbl[v].ev});
            if (tbl[v].ev) begin
                cmp($sformatf("v%0d_pc", v), fif.pc_out, tbl[v].epc);
                cmp($sformatf("v%0d_pc4", v), fif.pc_4_out, tbl[v].epc + 32'd4);
                cmp($sformatf("v%0d_instr", v), fif.instr_out, rom_val(tbl[v].epc));
            end
            cmp($sformatf("v%0d_pc_reg", v), fif.pc_reg, tbl[v].epc_reg);
            step(tbl[v].rv, tbl[v].rpc, tbl[v].rdy);
        end

        // Misaligned redirect target is forced to word alignment.
        step(1'b1, 32'h23, 1'b1);
        cmp("rd23_valid", {31'b0, fif.valid_out}, 32'h0);
        wait_valid(6);
        cmp("rd23_pc", fif.pc_out, 32'h20);
        cmp("rd23_pc4", fif.pc_4_out, 32'h24);
        cmp("rd23_instr", fif.instr_out, 32'h8);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        cmp("wrap_valid", {31'b0, fif.valid_out}, 32'h0);
        wait_valid(6);
        cmp("wrap_pc", fif.pc_out, 32'hFFFF_FFFC);
        cmp("wrap_pc4", fif.pc_4_out, 32'h0);
        cmp("wrap_instr", fif.instr_out, 32'h3FF);
        cmp("wrap_pc_reg", fif.pc_reg, 32'h4);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // Async reset mid-stream with the FIFO full.
        repeat (3) step(1'b0, 32'h0, 1'b0);
        cmp("pre_rst_valid", {31'b0, fif.valid_out}, 32'h1);
        #2 reset = 1'b1;
        #1;
        cmp("arst_valid", {31'b0, fif.valid_out}, 32'h0);
        cmp("arst_pc_reg", fif.pc_reg, 32'h0);
        cmp("arst_pc_out", fif.pc_out, 32'h0);
        cmp("arst_pc4", fif.pc_4_out, 32'h0);
        sb_refill(32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 32'h0, 1'b1);
        cmp("arst_e1_valid", {31'b0, fif.valid_out}, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        cmp("arst_e2_valid", {31'b0, fif.valid_out}, 32'h1);
        cmp("arst_e2_pc", fif.pc_out, 32'h0);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // Redirect coinciding with a fire and a pending push.
        step(1'b1, 32'h80, 1'b1);
        cmp("rdfire_valid", {31'b0, fif.valid_out}, 32'h0);
        cmp("rdfire_pc_reg", fif.pc_reg, 32'h80);
        step(1'b0, 32'h0, 1'b1);
        cmp("rdfire_e2_valid", {31'b0, fif.valid_out}, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        cmp("rdfire_e3_pc", fif.pc_out, 32'h80);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
